// File: rtl/lvds_rx_pkg.sv
// Shared constants, FSM state type and format helpers for the multi-lane LVDS deframer.
package lvds_rx_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned DATA_W   = 14;
  localparam int unsigned BEATS    = 7;
  localparam int unsigned BEAT_W   = 3;
  localparam int unsigned PAIRS_W  = 2;

  localparam logic [PAIRS_W-1:0] I_SYNC = 2'b10;
  localparam logic [PAIRS_W-1:0] Q_SYNC = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_I_DATA,
    ST_Q_SYNC,
    ST_Q_DATA,
    ST_I_SYNC
  } lane_state_e;

  function automatic logic [15:0] sext16(input logic [DATA_W-1:0] v);
    return {{(16 - DATA_W){v[DATA_W-1]}}, v};
  endfunction

endpackage

// File: rtl/lvds_rx_lane.sv
// One LVDS lane: registers the DDR pair, tracks I/Q frame sync and emits one push per good frame.
module lvds_rx_lane
  import lvds_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               i_ddr_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_mode,
  input  logic [PAIRS_W-1:0] i_pair,
  input  logic               i_fifo_full,
  output logic               o_fifo_push,
  output logic [FRAME_W-1:0] o_fifo_data,
  output logic               o_locked,
  output logic [CNT_W-1:0]   o_drop_cnt,
  output logic [CNT_W-1:0]   o_sync_err_cnt
);

  lane_state_e        state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               mode_q, mode_d;
  logic [PAIRS_W-1:0] pair_q;
  logic [FRAME_W-1:0] shift_q;
  logic               push_d;
  logic [FRAME_W-1:0] data_d;
  logic               locked_d;
  logic [CNT_W-1:0]   drop_d, err_d;
  logic [FRAME_W-1:0] fmt_c;

  // Shift register always holds the last 16 pairs, so at I_SYNC it is exactly the finished frame.
  assign fmt_c = mode_q ? {sext16(shift_q[FRAME_W-3 -: DATA_W]), sext16(shift_q[DATA_W-1:0])}
                        : shift_q;

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      beat_q         <= '0;
      mode_q         <= 1'b0;
      pair_q         <= '0;
      shift_q        <= '0;
      o_fifo_push    <= 1'b0;
      o_fifo_data    <= '0;
      o_locked       <= 1'b0;
      o_drop_cnt     <= '0;
      o_sync_err_cnt <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      mode_q         <= mode_d;
      pair_q         <= i_pair;
      shift_q        <= {shift_q[FRAME_W-PAIRS_W-1:0], pair_q};
      o_fifo_push    <= push_d;
      o_fifo_data    <= data_d;
      o_locked       <= locked_d;
      o_drop_cnt     <= drop_d;
      o_sync_err_cnt <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    push_d   = 1'b0;
    data_d   = o_fifo_data;
    locked_d = o_locked;
    drop_d   = o_drop_cnt;
    err_d    = o_sync_err_cnt;

    if (!i_enable) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        // Leaving IDLE only happens on an enable rising edge, which restarts the statistics.
        ST_IDLE: begin
          state_d = ST_HUNT;
          drop_d  = '0;
          err_d   = '0;
        end
        ST_HUNT: begin
          if (pair_q == I_SYNC) begin
            state_d = ST_I_DATA;
            beat_d  = '0;
            mode_d  = i_mode;
          end
        end
        ST_I_DATA: begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = ST_Q_SYNC;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        ST_Q_SYNC: begin
          if (pair_q == Q_SYNC) begin
            state_d = ST_Q_DATA;
            beat_d  = '0;
          end else begin
            state_d  = ST_HUNT;
            locked_d = 1'b0;
            if (o_locked && (o_sync_err_cnt != '1)) err_d = o_sync_err_cnt + CNT_W'(1);
          end
        end
        ST_Q_DATA: begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = ST_I_SYNC;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        ST_I_SYNC: begin
          locked_d = 1'b1;
          if (!i_fifo_full) begin
            push_d = 1'b1;
            data_d = fmt_c;
          end else if (o_drop_cnt != '1) begin
            drop_d = o_drop_cnt + CNT_W'(1);
          end
          if (pair_q == I_SYNC) begin
            state_d = ST_I_DATA;
            beat_d  = '0;
            mode_d  = i_mode;
          end else begin
            state_d  = ST_HUNT;
            locked_d = 1'b0;
            if (o_locked && (o_sync_err_cnt != '1)) err_d = o_sync_err_cnt + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lvds_rx_multi.sv
// N-lane LVDS I/Q deframer: one independent lvds_rx_lane per lane plus bus slicing.
module lvds_rx_multi
  import lvds_rx_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     i_ddr_clk,
  input  logic                     i_reset,
  input  logic [NCH-1:0]           i_enable,
  input  logic                     i_mode,
  input  logic [2*NCH-1:0]         i_ddr_data,
  input  logic [NCH-1:0]           i_fifo_full,
  output logic [NCH-1:0]           o_fifo_push,
  output logic [FRAME_W*NCH-1:0]   o_fifo_data,
  output logic [NCH-1:0]           o_locked,
  output logic [CNT_W*NCH-1:0]     o_drop_cnt,
  output logic [CNT_W*NCH-1:0]     o_sync_err_cnt
);

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    lvds_rx_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .i_ddr_clk     (i_ddr_clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable[k]),
      .i_mode        (i_mode),
      .i_pair        (i_ddr_data[PAIRS_W*k +: PAIRS_W]),
      .i_fifo_full   (i_fifo_full[k]),
      .o_fifo_push   (o_fifo_push[k]),
      .o_fifo_data   (o_fifo_data[FRAME_W*k +: FRAME_W]),
      .o_locked      (o_locked[k]),
      .o_drop_cnt    (o_drop_cnt[CNT_W*k +: CNT_W]),
      .o_sync_err_cnt(o_sync_err_cnt[CNT_W*k +: CNT_W])
    );
  end

endmodule
